// File: rtl/ds_sample_scheduler_if.sv
// Sample stream into the scheduler: valid/ready push handshake.
// The producer (host side) uses the master modport, and the scheduler uses the slave modport.
interface ds_sample_scheduler_if #(
  parameter int DATA_BITS = 16
);
  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ds_sample_scheduler.sv
// Sample scheduler for the delta-sigma PW modulator.
// Queues host samples in a small circular FIFO and waits until the FIFO is primed.
// It then hands one sample to the modulator every (rate+1) pulses.
// On underflow it holds the last value.
// When playback is stopped it ramps the output back to midscale so the output does not pop.
module ds_sample_scheduler #(
  parameter int                     SAMPLE_BITS = 16,
  parameter int                     DEPTH_LOG2  = 2,
  parameter int                     RATE_BITS   = 8,
  parameter int                     PRIME_LEVEL = 2,
  parameter logic [SAMPLE_BITS-1:0] RAMP_STEP   = 16'h0040
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [RATE_BITS-1:0]   rate,
  input  logic                   flush,
  ds_sample_scheduler_if.slave   in_if,
  input  logic                   pulse_done,
  input  logic                   clear_flags,
  output logic [SAMPLE_BITS-1:0] u_out,
  output logic                   u_update,
  output logic                   underflow,
  output logic [DEPTH_LOG2:0]    fill_level,
  output logic [1:0]             state
);

  localparam int                     DEPTH     = 1 << DEPTH_LOG2;
  localparam int                     LVL_BITS  = DEPTH_LOG2 + 1;
  localparam logic [LVL_BITS-1:0]    DEPTH_LVL = LVL_BITS'(DEPTH);
  localparam logic [LVL_BITS-1:0]    PRIME_LVL = LVL_BITS'(PRIME_LEVEL);
  localparam logic [LVL_BITS-1:0]    LVL_ZERO  = LVL_BITS'(0);
  localparam logic [LVL_BITS-1:0]    LVL_ONE   = LVL_BITS'(1);
  localparam logic [DEPTH_LOG2-1:0]  PTR_ZERO  = DEPTH_LOG2'(0);
  localparam logic [DEPTH_LOG2-1:0]  PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [RATE_BITS-1:0]   CNT_ZERO  = RATE_BITS'(0);
  localparam logic [RATE_BITS-1:0]   CNT_ONE   = RATE_BITS'(1);
  localparam logic [SAMPLE_BITS-1:0] MID       = {1'b1, {(SAMPLE_BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RAMP = 2'd2
  } state_t;

  state_t                  state_r;
  logic [SAMPLE_BITS-1:0]  u_out_r;
  logic                    u_update_r;
  logic                    underflow_r;
  logic [RATE_BITS-1:0]    tick_cnt_r;
  logic [SAMPLE_BITS-1:0]  mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_r;
  logic [DEPTH_LOG2-1:0]   rd_ptr_r;
  logic [LVL_BITS-1:0]     level_r;

  logic                    ready_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    tick_s;
  logic                    underflow_set_s;
  logic signed [SAMPLE_BITS:0] diff_s;
  logic [SAMPLE_BITS:0]    dist_s;
  logic                    near_mid_s;
  logic [SAMPLE_BITS-1:0]  ramp_val_s;
  logic [SAMPLE_BITS-1:0]  head_s;

  // Ready comes from the registered level, so it has no combinational path from in_valid.
  assign ready_s         = (level_r != DEPTH_LVL);
  assign in_if.in_ready  = ready_s;
  assign u_out           = u_out_r;
  assign u_update        = u_update_r;
  assign underflow       = underflow_r;
  assign fill_level      = level_r;
  assign state           = state_r;
  assign head_s          = mem_r[rd_ptr_r];

  // A sample tick is the pulse that ends a rate period. A flush in the same cycle blocks the push and the pop.
  always_comb begin
    tick_s          = (state_r != ST_IDLE) && pulse_done && (tick_cnt_r == CNT_ZERO);
    push_s          = in_if.in_valid && ready_s && !flush;
    pop_s           = (state_r == ST_RUN) && enable && tick_s && (level_r != LVL_ZERO) && !flush;
    underflow_set_s = (state_r == ST_RUN) && enable && tick_s && (level_r == LVL_ZERO);
  end

  // Distance from midscale with one extra bit, so the ramp step never wraps past MID.
  always_comb begin
    diff_s = $signed({1'b0, u_out_r}) - $signed({1'b0, MID});
    if (diff_s[SAMPLE_BITS]) begin
      dist_s     = unsigned'(-diff_s);
      ramp_val_s = u_out_r + RAMP_STEP;
    end else begin
      dist_s     = unsigned'(diff_s);
      ramp_val_s = u_out_r - RAMP_STEP;
    end
    near_mid_s = (dist_s <= {1'b0, RAMP_STEP});
  end

  // FIFO storage. Entries outside the head and tail are don't-care, so the storage is not reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_if.in_data;
    end
  end

  // FIFO pointers and fill level. A push and a pop in the same cycle leave the level unchanged.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Playback state machine, rate divider, sticky underflow and registered modulator outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      u_out_r     <= MID;
      u_update_r  <= 1'b0;
      underflow_r <= 1'b0;
      tick_cnt_r  <= CNT_ZERO;
    end else begin
      u_update_r <= 1'b0;

      // The rate is sampled only at reload, so a rate change takes effect at the next period.
      if (state_r == ST_IDLE) begin
        tick_cnt_r <= CNT_ZERO;
      end else if (pulse_done) begin
        tick_cnt_r <= (tick_cnt_r == CNT_ZERO) ? rate : (tick_cnt_r - CNT_ONE);
      end

      if (underflow_set_s) begin
        underflow_r <= 1'b1;
      end else if (clear_flags) begin
        underflow_r <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          u_out_r <= MID;
          if (enable && (level_r >= PRIME_LVL)) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state_r <= ST_RAMP;
          end else if (pop_s) begin
            u_out_r    <= head_s;
            u_update_r <= 1'b1;
          end
        end
        ST_RAMP: begin
          if (tick_s) begin
            if (near_mid_s) begin
              u_out_r    <= MID;
              u_update_r <= (u_out_r != MID);
              state_r    <= ST_IDLE;
            end else begin
              u_out_r    <= ramp_val_s;
              u_update_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          u_out_r <= MID;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ds_sample_scheduler.sv
// Self-checking bench for ds_sample_scheduler: directed scenarios plus a randomized
// run compared against a queue-based behavioural model.
module tb_ds_sample_scheduler;

  logic        clk = 1'b0;
  logic        reset, enable, flush, pulse_done, clear_flags;
  logic [7:0]  rate;
  logic [15:0] u_out;
  logic        u_update, underflow;
  logic [2:0]  fill_level;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [15:0] m_q[$];
  int          m_st;
  logic [15:0] m_u;
  logic        m_upd;
  logic        m_uf;
  int          m_tick;

  ds_sample_scheduler_if #(.DATA_BITS(16)) sif ();

  ds_sample_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .rate       (rate),
    .flush      (flush),
    .in_if      (sif),
    .pulse_done (pulse_done),
    .clear_flags(clear_flags),
    .u_out      (u_out),
    .u_update   (u_update),
    .underflow  (underflow),
    .fill_level (fill_level),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock from the inputs presented before the edge.
  task automatic model_advance();
    int  sz;
    bit  tick;
    bit  ready;
    int  d;
    int  nxt_tick;
    bit  do_pop;
    if (reset) begin
      m_q.delete(); m_st = 0; m_u = 16'h8000; m_upd = 1'b0; m_uf = 1'b0; m_tick = 0;
      return;
    end
    sz     = m_q.size();
    ready  = (sz != 4);
    tick   = (m_st != 0) && pulse_done && (m_tick == 0);
    if (m_st == 0) nxt_tick = 0;
    else if (pulse_done) nxt_tick = (m_tick == 0) ? int'(rate) : m_tick - 1;
    else nxt_tick = m_tick;
    m_upd  = 1'b0;
    do_pop = 1'b0;
    if (m_st == 0) begin
      m_u = 16'h8000;
      if (enable && sz >= 2) m_st = 1;
    end else if (m_st == 1) begin
      if (!enable) m_st = 2;
      else if (tick) begin
        if (sz == 0) m_uf = 1'b1;
        else if (!flush) begin m_u = m_q[0]; m_upd = 1'b1; do_pop = 1'b1; end
      end
      if (!(enable && tick && sz == 0) && clear_flags) m_uf = 1'b0;
    end else begin
      if (tick) begin
        d = int'(m_u) - 32768;
        if (d <= 64 && d >= -64) begin m_upd = (m_u != 16'h8000); m_u = 16'h8000; m_st = 0; end
        else if (d > 0) begin m_u = m_u - 16'h0040; m_upd = 1'b1; end
        else begin m_u = m_u + 16'h0040; m_upd = 1'b1; end
      end
    end
    if (m_st != 1 && clear_flags) m_uf = 1'b0;
    if (flush) m_q.delete();
    else begin
      if (do_pop) void'(m_q.pop_front());
      if (sif.in_valid && ready) m_q.push_back(sif.in_data);
    end
    m_tick = nxt_tick;
  endtask

  task automatic step();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; enable = 1'b0; flush = 1'b0; pulse_done = 1'b0; clear_flags = 1'b0;
    rate = 8'd0; sif.in_valid = 1'b0; sif.in_data = 16'h0000;
  endtask

  task automatic do_reset();
    idle_inputs(); reset = 1'b1; step(); reset = 1'b0;
  endtask

  task automatic push(input logic [15:0] v);
    sif.in_data = v; sif.in_valid = 1'b1; step(); sif.in_valid = 1'b0;
  endtask

  task automatic pulse();
    pulse_done = 1'b1; step(); pulse_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (u_out !== 16'h8000) begin errors++; $display("FAIL reset_u_out: got %h expected %h", u_out, 16'h8000); end
    checks++; if (sif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", sif.in_ready); end
    checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", fill_level); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
    checks++; if (u_update !== 1'b0) begin errors++; $display("FAIL reset_u_update: got %b expected 0", u_update); end
  endtask

  task automatic test_playback();
    int upd_cnt = 0;
    do_reset();
    rate = 8'd3;
    push(16'h1000); push(16'h2000); push(16'h3000);
    enable = 1'b1; step();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL play_state: got %0d expected 1", state); end
    for (int p = 1; p <= 12; p++) begin
      pulse();
      upd_cnt += int'(u_update);
      if (p == 1) begin checks++; if (u_out !== 16'h1000 || u_update !== 1'b1) begin errors++; $display("FAIL play_p1: got %h/%b expected 1000/1", u_out, u_update); end end
      if (p == 4) begin checks++; if (u_out !== 16'h1000) begin errors++; $display("FAIL play_p4: got %h expected 1000", u_out); end end
      if (p == 5) begin checks++; if (u_out !== 16'h2000) begin errors++; $display("FAIL play_p5: got %h expected 2000", u_out); end end
      if (p == 9) begin checks++; if (u_out !== 16'h3000) begin errors++; $display("FAIL play_p9: got %h expected 3000", u_out); end end
      step();
      upd_cnt += int'(u_update);
    end
    checks++; if (upd_cnt != 3) begin errors++; $display("FAIL play_updates: got %0d expected 3", upd_cnt); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL play_underflow: got %b expected 0", underflow); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    push(16'hA001); push(16'hA002); push(16'hA003); push(16'hA004);
    checks++; if (fill_level !== 3'd4 || sif.in_ready !== 1'b0) begin errors++; $display("FAIL full_level: got %0d/%b expected 4/0", fill_level, sif.in_ready); end
    push(16'hEEEE);
    checks++; if (fill_level !== 3'd4) begin errors++; $display("FAIL full_drop: got %0d expected 4", fill_level); end
    rate = 8'd0; enable = 1'b1; step();
    pulse();
    checks++; if (u_out !== 16'hA001 || fill_level !== 3'd3) begin errors++; $display("FAIL full_pop1: got %h/%0d expected a001/3", u_out, fill_level); end
    sif.in_data = 16'hA005; sif.in_valid = 1'b1; pulse_done = 1'b1; step();
    sif.in_valid = 1'b0; pulse_done = 1'b0;
    checks++; if (fill_level !== 3'd3 || u_out !== 16'hA002) begin errors++; $display("FAIL push_pop_same: got %0d/%h expected 3/a002", fill_level, u_out); end
    pulse(); pulse();
    checks++; if (u_out !== 16'hA004) begin errors++; $display("FAIL full_order4: got %h expected a004", u_out); end
    pulse();
    checks++; if (u_out !== 16'hA005 || fill_level !== 3'd0) begin errors++; $display("FAIL full_order5: got %h/%0d expected a005/0", u_out, fill_level); end
  endtask

  task automatic test_underflow();
    do_reset();
    rate = 8'd0;
    push(16'h1111); push(16'h2222);
    enable = 1'b1; step();
    pulse(); pulse();
    checks++; if (u_out !== 16'h2222 || underflow !== 1'b0) begin errors++; $display("FAIL uf_before: got %h/%b expected 2222/0", u_out, underflow); end
    pulse();
    checks++; if (underflow !== 1'b1 || u_out !== 16'h2222 || u_update !== 1'b0 || state !== 2'd1) begin errors++; $display("FAIL uf_set: got uf=%b u=%h upd=%b st=%0d expected 1/2222/0/1", underflow, u_out, u_update, state); end
    clear_flags = 1'b1; pulse(); clear_flags = 1'b0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_priority: got %b expected 1", underflow); end
    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b expected 0", underflow); end
  endtask

  task automatic test_ramp();
    logic [15:0] exp_r [4] = '{16'h80C0, 16'h8080, 16'h8040, 16'h8000};
    do_reset();
    rate = 8'd0;
    push(16'h8100); push(16'h1234);
    enable = 1'b1; step();
    pulse();
    checks++; if (u_out !== 16'h8100) begin errors++; $display("FAIL ramp_start: got %h expected 8100", u_out); end
    enable = 1'b0; step();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL ramp_enter: got %0d expected 2", state); end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pulse();
      checks++; if (u_out !== exp_r[i] || u_update !== 1'b1) begin errors++; $display("FAIL ramp_step%0d: got %h/%b expected %h/1", i, u_out, u_update, exp_r[i]); end
      checks++; if (state !== ((i == 3) ? 2'd0 : 2'd2)) begin errors++; $display("FAIL ramp_state%0d: got %0d expected %0d", i, state, (i == 3) ? 0 : 2); end
    end
    checks++; if (fill_level !== 3'd1) begin errors++; $display("FAIL ramp_fifo_kept: got %0d expected 1", fill_level); end
    push(16'h5678); step();
    pulse();
    checks++; if (u_out !== 16'h1234) begin errors++; $display("FAIL ramp_fifo_head: got %h expected 1234", u_out); end
    do_reset();
    push(16'h0001); push(16'h0002);
    enable = 1'b1; step();
    enable = 1'b0; step();
    pulse();
    checks++; if (state !== 2'd0 || u_update !== 1'b0 || u_out !== 16'h8000) begin errors++; $display("FAIL ramp_at_mid: got st=%0d upd=%b u=%h expected 0/0/8000", state, u_update, u_out); end
  endtask

  task automatic test_reset_flush();
    do_reset();
    rate = 8'd1;
    push(16'h0AAA); push(16'h0BBB); push(16'h0CCC);
    enable = 1'b1; step();
    reset = 1'b1; pulse_done = 1'b1; step(); reset = 1'b0; pulse_done = 1'b0;
    checks++; if (fill_level !== 3'd0 || state !== 2'd0 || u_out !== 16'h8000 || u_update !== 1'b0 || sif.in_ready !== 1'b1) begin errors++; $display("FAIL midrun_reset: got lvl=%0d st=%0d u=%h upd=%b rdy=%b", fill_level, state, u_out, u_update, sif.in_ready); end
    enable = 1'b0;
    push(16'h0DDD); push(16'h0EEE);
    sif.in_data = 16'h0FFF; sif.in_valid = 1'b1; flush = 1'b1; step();
    sif.in_valid = 1'b0; flush = 1'b0;
    checks++; if (fill_level !== 3'd0 || sif.in_ready !== 1'b1) begin errors++; $display("FAIL flush_push: got %0d/%b expected 0/1", fill_level, sif.in_ready); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) < 4) enable = ~enable;
      if ($urandom_range(0, 99) < 5) rate = 8'($urandom_range(0, 3));
      flush        = ($urandom_range(0, 99) < 2);
      sif.in_valid = ($urandom_range(0, 99) < 45);
      sif.in_data  = 16'($urandom);
      pulse_done   = ($urandom_range(0, 99) < 40);
      clear_flags  = ($urandom_range(0, 99) < 5);
      step();
      checks++; if (u_out !== m_u) begin errors++; $display("FAIL rnd_u_out c=%0d: got %h expected %h", c, u_out, m_u); end
      checks++; if (u_update !== m_upd) begin errors++; $display("FAIL rnd_u_update c=%0d: got %b expected %b", c, u_update, m_upd); end
      checks++; if (underflow !== m_uf) begin errors++; $display("FAIL rnd_underflow c=%0d: got %b expected %b", c, underflow, m_uf); end
      checks++; if (fill_level !== 3'(m_q.size())) begin errors++; $display("FAIL rnd_fill c=%0d: got %0d expected %0d", c, fill_level, m_q.size()); end
      checks++; if (state !== 2'(m_st)) begin errors++; $display("FAIL rnd_state c=%0d: got %0d expected %0d", c, state, m_st); end
      checks++; if (sif.in_ready !== (m_q.size() != 4)) begin errors++; $display("FAIL rnd_ready c=%0d: got %b expected %b", c, sif.in_ready, m_q.size() != 4); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_playback();
    test_fifo_full();
    test_underflow();
    test_ramp();
    test_reset_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
